// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared types and defaults for the instruction-fetch path. The state
// encoding is also used by the decoder and by the bench.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int DATA_LEN_DEF       = 16;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_BRANCH = 3'd4
    } fetch_state_t;

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_timeout_counter.sv
// -----------------------------------------------------------------------------
// fetch_timeout_counter
// Down-counter that flags the cycle in which i_limit enabled cycles have
// elapsed since the last clear.
//
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   i_clear      reload the counter (the cycle before counting starts)
//   i_enable     count this cycle
//   i_limit      number of enabled cycles until expiry (must be >= 1)
//   o_expired    high in the enabled cycle that reaches the limit
// -----------------------------------------------------------------------------
module fetch_timeout_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    // Loading limit-1 makes the terminal count (zero) coincide with the
    // limit-th enabled cycle, so expiry needs no extra cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= i_limit - CNT_W'(1);
        end else if (i_enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expired = i_enable && (r_cnt == '0);

endmodule : fetch_timeout_counter

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller in front of the PC register. Fetches the word
// at the PC over a req/ready handshake, hands it to the decoder over a
// valid/ack handshake, and strobes PC increment (at capture) or PC load
// (on a taken branch). All outputs are registered.
//
// Build option: FETCH_TIMEOUT_EN adds a WAIT-state timeout that raises a
// sticky o_fetch_err and parks the sequencer in IDLE.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   i_run               keep fetching while high
//   i_pc_in             current PC value
//   o_pc_inc, o_pc_we   PC increment / load strobes (never together)
//   o_c_bus_out         branch target for the PC load
//   o_imem_req/addr     instruction memory read request and address
//   i_imem_ready/rdata  instruction memory response
//   o_ir_out/valid      captured instruction to the decoder
//   i_ir_ack            decoder consumed the instruction
//   i_branch_req/target branch request, sampled with i_ir_ack
//   o_fetch_err         sticky timeout flag
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | stopped; waits for i_run
// ST_REQ    | latch PC as fetch address, raise request
// ST_WAIT   | request outstanding; waiting for i_imem_ready
// ST_HOLD   | instruction presented; waiting for i_ir_ack
// ST_BRANCH | o_pc_we high; PC loads the target at the end of this cycle
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int DATA_LEN       = DATA_LEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_run,
    input  logic [DATA_LEN-1:0] i_pc_in,
    output logic                o_pc_inc,
    output logic                o_pc_we,
    output logic [DATA_LEN-1:0] o_c_bus_out,
    output logic                o_imem_req,
    output logic [DATA_LEN-1:0] o_imem_addr,
    input  logic                i_imem_ready,
    input  logic [DATA_LEN-1:0] i_imem_rdata,
    output logic [DATA_LEN-1:0] o_ir_out,
    output logic                o_ir_valid,
    input  logic                i_ir_ack,
    input  logic                i_branch_req,
    input  logic [DATA_LEN-1:0] i_branch_target,
    output logic                o_fetch_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_t        r_state, w_state_nxt;
    logic                r_imem_req, w_imem_req_nxt;
    logic [DATA_LEN-1:0] r_imem_addr, w_imem_addr_nxt;
    logic [DATA_LEN-1:0] r_ir_out, w_ir_out_nxt;
    logic                r_ir_valid, w_ir_valid_nxt;
    logic                r_pc_inc, w_pc_inc_nxt;
    logic                r_pc_we, w_pc_we_nxt;
    logic [DATA_LEN-1:0] r_c_bus_out, w_c_bus_out_nxt;
    logic                w_run_ok;
    logic                w_expired;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic r_fetch_err, w_fetch_err_nxt;
    logic w_cnt_clear;
    logic w_cnt_enable;

    // Reloading in REQ means the count is fresh on the first WAIT cycle.
    assign w_cnt_clear  = (r_state == ST_REQ);
    assign w_cnt_enable = (r_state == ST_WAIT) && !i_imem_ready;

    fetch_timeout_counter #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .i_limit   (TO_LIMIT),
        .o_expired (w_expired)
    );

    // A latched error parks the sequencer until reset.
    assign w_run_ok    = i_run && !r_fetch_err;
    assign o_fetch_err = r_fetch_err;
`else
    assign w_expired   = 1'b0;
    assign w_run_ok    = i_run;
    assign o_fetch_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_imem_req_nxt  = r_imem_req;
        w_imem_addr_nxt = r_imem_addr;
        w_ir_out_nxt    = r_ir_out;
        w_ir_valid_nxt  = r_ir_valid;
        w_pc_inc_nxt    = 1'b0;
        w_pc_we_nxt     = 1'b0;
        w_c_bus_out_nxt = r_c_bus_out;
`ifdef FETCH_TIMEOUT_EN
        w_fetch_err_nxt = r_fetch_err;
`endif

        unique case (r_state)
            ST_IDLE: begin
                if (w_run_ok) begin
                    w_state_nxt = ST_REQ;
                end
            end

            ST_REQ: begin
                w_imem_req_nxt  = 1'b1;
                w_imem_addr_nxt = i_pc_in;
                w_state_nxt     = ST_WAIT;
            end

            ST_WAIT: begin
                if (i_imem_ready) begin
                    // Increment at capture so the PC is already PC+1 by the
                    // time the next REQ samples it.
                    w_ir_out_nxt   = i_imem_rdata;
                    w_ir_valid_nxt = 1'b1;
                    w_imem_req_nxt = 1'b0;
                    w_pc_inc_nxt   = 1'b1;
                    w_state_nxt    = ST_HOLD;
                end else if (w_expired) begin
                    w_imem_req_nxt = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    w_fetch_err_nxt = 1'b1;
`endif
                    w_state_nxt    = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (i_ir_ack && r_ir_valid) begin
                    w_ir_valid_nxt = 1'b0;
                    if (i_branch_req) begin
                        // pc_inc fired in the capture cycle, which is already
                        // behind us, so the load cannot collide with it.
                        w_c_bus_out_nxt = i_branch_target;
                        w_pc_we_nxt     = 1'b1;
                        w_state_nxt     = ST_BRANCH;
                    end else if (w_run_ok) begin
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_BRANCH: begin
                w_state_nxt = w_run_ok ? ST_REQ : ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_ir_out    <= '0;
            r_ir_valid  <= 1'b0;
            r_pc_inc    <= 1'b0;
            r_pc_we     <= 1'b0;
            r_c_bus_out <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_imem_req  <= w_imem_req_nxt;
            r_imem_addr <= w_imem_addr_nxt;
            r_ir_out    <= w_ir_out_nxt;
            r_ir_valid  <= w_ir_valid_nxt;
            r_pc_inc    <= w_pc_inc_nxt;
            r_pc_we     <= w_pc_we_nxt;
            r_c_bus_out <= w_c_bus_out_nxt;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_err <= 1'b0;
        end else begin
            r_fetch_err <= w_fetch_err_nxt;
        end
    end
`endif

    assign o_pc_inc    = r_pc_inc;
    assign o_pc_we     = r_pc_we;
    assign o_c_bus_out = r_c_bus_out;
    assign o_imem_req  = r_imem_req;
    assign o_imem_addr = r_imem_addr;
    assign o_ir_out    = r_ir_out;
    assign o_ir_valid  = r_ir_valid;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer with a behavioural PC register and an
// instruction-word scoreboard. Timeout checks apply when FETCH_TIMEOUT_EN is
// defined (the DUT is built with TIMEOUT_CYCLES=4).
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int DL = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_run;
    logic [DL-1:0] pc;
    logic          o_pc_inc, o_pc_we;
    logic [DL-1:0] o_c_bus_out;
    logic          o_imem_req;
    logic [DL-1:0] o_imem_addr;
    logic          i_imem_ready;
    logic [DL-1:0] i_imem_rdata;
    logic [DL-1:0] o_ir_out;
    logic          o_ir_valid;
    logic          i_ir_ack, i_branch_req;
    logic [DL-1:0] i_branch_target;
    logic          o_fetch_err;

    logic          pc_force;
    logic [DL-1:0] pc_force_val;

    int n_cmp = 0;
    int n_err = 0;
    int n_inc = 0;
    int n_overlap = 0;
    logic [DL-1:0] sb_q[$];

    always #5 clk = ~clk;

    fetch_sequencer #(.DATA_LEN(DL), .TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_run           (i_run),
        .i_pc_in         (pc),
        .o_pc_inc        (o_pc_inc),
        .o_pc_we         (o_pc_we),
        .o_c_bus_out     (o_c_bus_out),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_ready    (i_imem_ready),
        .i_imem_rdata    (i_imem_rdata),
        .o_ir_out        (o_ir_out),
        .o_ir_valid      (o_ir_valid),
        .i_ir_ack        (i_ir_ack),
        .i_branch_req    (i_branch_req),
        .i_branch_target (i_branch_target),
        .o_fetch_err     (o_fetch_err)
    );

    // PC register model: increment has priority over load.
    always @(posedge clk) begin
        if (pc_force)      pc <= pc_force_val;
        else if (o_pc_inc) pc <= pc + 16'd1;
        else if (o_pc_we)  pc <= o_c_bus_out;
    end

    always @(posedge clk) begin
        if (rst_n && o_pc_inc) n_inc++;
        if (rst_n && o_pc_inc && o_pc_we) n_overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_imem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_req_seen"}, {31'd0, seen}, 32'd1);
    endtask

    // One full fetch: respond after ready_dly WAIT cycles, ack after ack_dly
    // HOLD cycles, optionally with a branch or with run dropped before ack.
    task automatic do_fetch(input string tag, input logic [DL-1:0] exp_addr,
                            input logic [DL-1:0] rdata, input int ready_dly,
                            input int ack_dly, input bit br,
                            input logic [DL-1:0] tgt, input bit stop);
        int inc0;
        logic [DL-1:0] exp_ir;
        wait_req(tag);
        inc0 = n_inc;
        chk({tag, "_addr"}, o_imem_addr, exp_addr);
        for (int d = 0; d < ready_dly; d++) begin
            @(negedge clk);
            chk({tag, "_req_held"}, o_imem_req, 1);
            chk({tag, "_addr_held"}, o_imem_addr, exp_addr);
            chk({tag, "_no_early_valid"}, o_ir_valid, 0);
        end
        i_imem_ready = 1'b1;
        i_imem_rdata = rdata;
        sb_q.push_back(rdata);
        @(negedge clk);
        i_imem_ready = 1'b0;
        i_imem_rdata = 16'hxxxx;
        if (stop) i_run = 1'b0;
        chk({tag, "_valid"}, o_ir_valid, 1);
        chk({tag, "_req_drop"}, o_imem_req, 0);
        chk({tag, "_pc_inc"}, o_pc_inc, 1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            exp_ir = sb_q.pop_front();
            chk({tag, "_ir_out"}, o_ir_out, exp_ir);
        end
        for (int d = 0; d < ack_dly; d++) begin
            @(negedge clk);
            chk({tag, "_valid_held"}, o_ir_valid, 1);
        end
        i_ir_ack        = 1'b1;
        i_branch_req    = br;
        i_branch_target = tgt;
        @(negedge clk);
        i_ir_ack     = 1'b0;
        i_branch_req = 1'b0;
        chk({tag, "_valid_clr"}, o_ir_valid, 0);
        chk({tag, "_pc_we"}, o_pc_we, br);
        chk({tag, "_one_inc"}, n_inc - inc0, 1);
        if (br) begin
            chk({tag, "_c_bus"}, o_c_bus_out, tgt);
            chk({tag, "_no_inc_with_we"}, o_pc_inc, 0);
            @(negedge clk);
            chk({tag, "_we_pulse"}, o_pc_we, 0);
        end
    endtask

    initial begin
        int inc0;
        rst_n = 1'b0;
        i_run = 1'b0;
        i_imem_ready = 1'b0;
        i_imem_rdata = '0;
        i_ir_ack = 1'b0;
        i_branch_req = 1'b0;
        i_branch_target = '0;
        pc_force = 1'b1;
        pc_force_val = 16'h0010;
        repeat (3) @(negedge clk);

        chk("rst_req", o_imem_req, 0);
        chk("rst_addr", o_imem_addr, 0);
        chk("rst_ir_out", o_ir_out, 0);
        chk("rst_valid", o_ir_valid, 0);
        chk("rst_pc_inc", o_pc_inc, 0);
        chk("rst_pc_we", o_pc_we, 0);
        chk("rst_c_bus", o_c_bus_out, 0);
        chk("rst_err", o_fetch_err, 0);
        chk("rst_state", dut.r_state, ST_IDLE);

        rst_n = 1'b1;
        pc_force = 1'b0;
        i_run = 1'b1;

        do_fetch("t1", 16'h0010, 16'hA5A5, 0, 0, 1'b0, 16'h0000, 1'b0);
        do_fetch("t2", 16'h0011, 16'h1234, 5, 3, 1'b0, 16'h0000, 1'b0);
        do_fetch("t3", 16'h0012, 16'h5A5A, 1, 0, 1'b1, 16'h0200, 1'b0);
        do_fetch("t4", 16'h0200, 16'hBEEF, 0, 2, 1'b0, 16'h0000, 1'b1);

        chk("stop_state", dut.r_state, ST_IDLE);
        repeat (4) @(negedge clk);
        chk("stop_no_req", o_imem_req, 0);
        chk("stop_state_hold", dut.r_state, ST_IDLE);

        // Reset while WAIT, then a stale ready after release.
        i_run = 1'b1;
        wait_req("rw");
        inc0 = n_inc;
        i_run = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rw_req", o_imem_req, 0);
        chk("rw_addr", o_imem_addr, 0);
        chk("rw_ir_out", o_ir_out, 0);
        chk("rw_valid", o_ir_valid, 0);
        chk("rw_c_bus", o_c_bus_out, 0);
        chk("rw_state", dut.r_state, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        i_imem_ready = 1'b1;
        i_imem_rdata = 16'hDEAD;
        repeat (3) begin
            @(negedge clk);
            chk("rw_no_valid", o_ir_valid, 0);
            chk("rw_no_capture", o_ir_out, 0);
            chk("rw_no_req", o_imem_req, 0);
        end
        i_imem_ready = 1'b0;
        chk("rw_no_inc", n_inc - inc0, 0);
        chk("rw_state_idle", dut.r_state, ST_IDLE);

`ifdef FETCH_TIMEOUT_EN
        pc_force = 1'b1;
        pc_force_val = 16'h0040;
        @(negedge clk);
        pc_force = 1'b0;
        i_run = 1'b1;
        wait_req("to");
        inc0 = n_inc;
        chk("to_addr", o_imem_addr, 16'h0040);
        repeat (3) begin
            @(negedge clk);
            chk("to_err_low", o_fetch_err, 0);
            chk("to_req_held", o_imem_req, 1);
        end
        @(negedge clk);
        chk("to_err_set", o_fetch_err, 1);
        chk("to_req_drop", o_imem_req, 0);
        chk("to_valid", o_ir_valid, 0);
        chk("to_state", dut.r_state, ST_IDLE);
        repeat (8) begin
            @(negedge clk);
            chk("to_parked_req", o_imem_req, 0);
            chk("to_sticky", o_fetch_err, 1);
        end
        chk("to_parked_state", dut.r_state, ST_IDLE);
        chk("to_no_inc", n_inc - inc0, 0);
`else
        i_run = 1'b1;
        do_fetch("t5", 16'h0201, 16'h0F0F, 7, 0, 1'b0, 16'h0000, 1'b1);
        chk("no_err", o_fetch_err, 0);
`endif

        chk("no_overlap", n_overlap, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fetch_sequencer

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that sits directly upstream of the program-counter register.
- Drives the PC's increment and write-enable strobes and its c-bus load value.
- Fetches the word at the current PC from instruction memory using a req/ready handshake.
- Presents the captured instruction to the decoder using a valid/ack handshake.
- Sequences the next fetch: fall-through or branch.

Parameters:
DATA_LEN, 16, width of PC, instruction memory address, instruction word and c-bus.
TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only when FETCH_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_n  input  1  asynchronous, active-low reset
run  input  1  level; 1 = keep fetching, 0 = stop after current instruction is acked
pc_in  input  DATA_LEN  current PC register value
pc_inc  output  1  one-cycle strobe; PC increments
pc_we  output  1  one-cycle strobe; PC loads c_bus_out
c_bus_out  output  DATA_LEN  branch target driven to PC c-bus input
imem_req  output  1  read request, level
imem_addr  output  DATA_LEN  read address, stable while imem_req=1
imem_ready  input  1  read data valid this cycle
imem_rdata  input  DATA_LEN  instruction word
ir_out  output  DATA_LEN  captured instruction
ir_valid  output  1  ir_out valid for decoder
ir_ack  input  1  decoder consumed ir_out
branch_req  input  1  sampled only with ir_ack; take branch
branch_target  input  DATA_LEN  sampled with ir_ack&branch_req
fetch_err  output  1  sticky fetch timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: imem_req, imem_addr, ir_out, ir_valid, pc_inc, pc_we, c_bus_out, fetch_err.
  - Reset mid-fetch aborts immediately; any in-flight imem_ready after reset release is ignored until a new req is issued.
- All outputs are registered.
- States: IDLE, REQ, WAIT, HOLD, BRANCH.
- IDLE: run=1 -> REQ.
- REQ (one cycle): imem_req<=1, imem_addr<=pc_in -> WAIT.
- WAIT:
  - imem_req and imem_addr held.
  - On imem_ready=1: ir_out<=imem_rdata, ir_valid<=1, imem_req<=0, pc_inc<=1 for exactly one cycle -> HOLD.
- Minimum req-to-ir_valid latency is 2 cycles (ready in the first WAIT cycle).
- HOLD:
  - ir_valid held at 1 until ir_ack=1.
  - On ack: ir_valid<=0.
    - branch_req=1: c_bus_out<=branch_target, pc_we<=1 for one cycle -> BRANCH.
    - branch_req=0: run=1 -> REQ; run=0 -> IDLE.
  - The PC increment from the capture cycle has completed before REQ, so the next fetch addresses PC+1.
- BRANCH (one cycle): PC loads target at end of this cycle; run=1 -> REQ, else IDLE.
- pc_inc and pc_we are never asserted in the same cycle. The PC register gives inc priority, so overlap would drop the branch.
- The increment is issued at capture, not at ack. A taken branch therefore overwrites PC+1.
- PC arithmetic wraps modulo 2^DATA_LEN; this is owned by the PC register, with no special handling here.
- run falling during WAIT/HOLD: the current instruction completes and is handed off; no new REQ is issued.
- ir_ack while ir_valid=0 is ignored. branch_req without ir_ack is ignored.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without imem_ready.
  - At TIMEOUT_CYCLES: fetch_err<=1 (sticky until rst_n), imem_req<=0, no pc_inc -> IDLE.
  - While fetch_err=1, run is ignored.
- Undefined: WAIT waits indefinitely; fetch_err is tied to 0; no counter logic.

Decomposition:
- Shared package: state encoding enum (IDLE/REQ/WAIT/HOLD/BRANCH) and the DATA_LEN default. Both are reused by the decoder and the bench.
- Timeout counter is a natural sub-module: fetch_timeout_counter (clear, enable, limit, expired).
- The FSM stays in fetch_sequencer.

Test Plan:
- Reset then run=1, pc_in=0x0010, imem_ready in first WAIT cycle, rdata=0xA5A5 -> imem_addr=0x0010; ir_out=0xA5A5 and ir_valid 2 cycles after REQ; single pc_inc pulse.
- imem_ready delayed 5 cycles -> imem_req/imem_addr stable throughout; exactly one pc_inc; no ir_valid before ready.
- ir_ack delayed 3 cycles after ir_valid -> ir_valid held; next REQ addresses 0x0011.
- ir_ack with branch_req=1, branch_target=0x0200 -> pc_we one cycle with c_bus_out=0x0200; never overlaps pc_inc; next imem_addr=0x0200.
- rst_n pulled low in WAIT, then ready arrives after release with run=0 -> all outputs 0, state IDLE, no capture.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, imem_ready never asserted -> fetch_err=1 after 4 WAIT cycles; imem_req=0; no pc_inc; stays IDLE despite run=1.
